sargantana_icache_checker_pipe: RTL and testbench
=================================================

# sargantana_icache_checker_pipe

Registered, parametrised tag-check and fetch-chunk selection stage for the Sargantana instruction cache. It compares the MMU physical tag against all way tags, selects the requested FETCH_WIDTH chunk from the hit way, and returns the result one cycle later through a valid/ready handshake. It adds flush, multi-hit detection and saturating hit/miss performance counters. It sits between the tag/data SRAM read port and the fetch-side response logic of the icache controller.

## Interface
- ICACHE_N_WAY, 4: number of ways (power of two, ≥2)
- TAG_WIDTH, 20: physical tag width
- LINE_WIDTH, 512: cache line width in bits
- FETCH_WIDTH, 128: returned chunk width; LINE_WIDTH/FETCH_WIDTH is a power of two ≥2
- CNT_WIDTH, 32: performance counter width
- Derived: N_CHUNK = LINE_WIDTH/FETCH_WIDTH, CHUNK_IDX_W = $clog2(N_CHUNK), WAY_IDX_W = $clog2(ICACHE_N_WAY)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard the in-flight result
- req_valid_i  in  1  tag and data read valid this cycle
- req_ready_o  out  1  stage can accept a request
- req_tag_i  in  TAG_WIDTH  physical tag from the MMU
- req_chunk_i  in  CHUNK_IDX_W  chunk index inside the line
- way_valid_i  in  ICACHE_N_WAY  per-way valid bits
- read_tags_i  in  ICACHE_N_WAY×TAG_WIDTH  per-way tags read
- data_rd_i  in  ICACHE_N_WAY×LINE_WIDTH  per-way lines read
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts the response
- rsp_hit_o  out  1  single-way hit
- rsp_way_o  out  WAY_IDX_W  hit way index (0 on miss)
- rsp_multihit_o  out  1  more than one way matched (error)
- rsp_data_o  out  FETCH_WIDTH  selected chunk (0 unless rsp_hit_o)
- cnt_clear_i  in  1  synchronously clear both counters
- hit_cnt_o  out  CNT_WIDTH  accepted hit responses
- miss_cnt_o  out  CNT_WIDTH  accepted miss and multihit responses

## Operation
- Compare (combinational, in the request cycle): hit_vec[w] = (read_tags_i[w] == req_tag_i) & way_valid_i[w].
  - Lowest set index wins; that index is sel_way.
  - multihit = popcount(hit_vec) > 1.
  - chunk = data_rd_i[sel_way][req_chunk_i*FETCH_WIDTH +: FETCH_WIDTH].
- Output register: on the request handshake (req_valid_i & req_ready_o) the register loads:
  - hit = |hit_vec & ~multihit
  - way = hit ? sel_way : 0
  - multihit
  - data = hit ? chunk : 0
  - valid_q is set to 1.
- req_ready_o = ~flush_i & (~valid_q | rsp_ready_i). A response consumed in the same cycle as a new load is a back-to-back transfer.
- On a response handshake (rsp_valid_o & rsp_ready_i) with no new load, valid_q clears.
- Data and way fields are held stable while rsp_valid_o=1 and rsp_ready_i=0.
- Flush:
  - While flush_i=1, rsp_valid_o is forced to 0 and req_ready_o is forced to 0.
  - valid_q clears on the next edge. Flush takes priority over any load or handshake.
  - A response killed by flush is never counted.
- Counters update on each response handshake.
  - hit_cnt_o increments if rsp_hit_o=1; otherwise miss_cnt_o increments.
  - Both saturate at 2^CNT_WIDTH-1.
  - cnt_clear_i has priority over an increment in the same cycle; both counters read 0 the next cycle.
- Multihit responses carry rsp_hit_o=0 and rsp_data_o=0, and are counted as misses.

## Timing
- Latency is 1 cycle: a request accepted at edge N produces rsp_valid_o=1 after edge N.
- Throughput is 1 response per cycle while rsp_ready_i=1.
- rsp_valid_o depends combinationally only on valid_q and flush_i. The data path from request to response is fully registered.
- Reset values: rsp_valid_o=0, rsp_hit_o=0, rsp_way_o=0, rsp_multihit_o=0, rsp_data_o=0, hit_cnt_o=0, miss_cnt_o=0.
- req_ready_o is 1 after reset when flush_i=0.
- Reset asserted mid-operation discards the pending response immediately (asynchronous). Counters clear.
- req_valid_i=1 with req_ready_o=0 is ignored. The requester must hold the request; the block has no internal buffer.

## Test plan
- Single hit: way 2 tag=0x12345 valid, req_tag=0x12345, chunk=3, LINE 512/FETCH 128 -> 1 cycle later rsp_hit=1, rsp_way=2, rsp_data=data_rd[2][511:384], hit_cnt=1 after ready.
- Miss and valid-bit gating: tags match in way 1 but way_valid=4'b0000 -> rsp_hit=0, rsp_data=0, rsp_way=0, miss_cnt=1.
- Multihit: ways 0 and 3 match and are valid -> rsp_multihit=1, rsp_hit=0, rsp_data=0, miss_cnt increments.
- Backpressure then back-to-back: hold rsp_ready_i=0 for 3 cycles -> req_ready_o=0 and output stable. Then ready=1 with continuous requests -> one response per cycle, in order.
- Flush: assert flush_i with valid_q=1 and rsp_ready_i=1 -> rsp_valid_o=0 that cycle, no counter change, valid_q=0 the next cycle.
- Counters: preload near 2^CNT_WIDTH-1 (CNT_WIDTH=4, 16 hits) -> hit_cnt holds at 15. cnt_clear_i coincident with a hit -> 0. Async reset mid-stream -> all outputs 0.

Source files
------------

// File: rtl/sargantana_icache_checker_pipe.sv
// rtl/sargantana_icache_checker_pipe.sv - registered icache tag check and fetch-chunk select stage
// Compares the physical tag against all ways, picks the fetch chunk of the hit way, returns it one cycle later.
module sargantana_icache_checker_pipe #(
  parameter int ICACHE_N_WAY = 4,
  parameter int TAG_WIDTH    = 20,
  parameter int LINE_WIDTH   = 512,
  parameter int FETCH_WIDTH  = 128,
  parameter int CNT_WIDTH    = 32,
  localparam int N_CHUNK     = LINE_WIDTH / FETCH_WIDTH,
  localparam int CHUNK_IDX_W = $clog2(N_CHUNK),
  localparam int WAY_IDX_W   = $clog2(ICACHE_N_WAY)
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 flush_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [TAG_WIDTH-1:0]                 req_tag_i,
  input  logic [CHUNK_IDX_W-1:0]               req_chunk_i,
  input  logic [ICACHE_N_WAY-1:0]              way_valid_i,
  input  logic [ICACHE_N_WAY*TAG_WIDTH-1:0]    read_tags_i,
  input  logic [ICACHE_N_WAY*LINE_WIDTH-1:0]   data_rd_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic                                 rsp_hit_o,
  output logic [WAY_IDX_W-1:0]                 rsp_way_o,
  output logic                                 rsp_multihit_o,
  output logic [FETCH_WIDTH-1:0]               rsp_data_o,
  input  logic                                 cnt_clear_i,
  output logic [CNT_WIDTH-1:0]                 hit_cnt_o,
  output logic [CNT_WIDTH-1:0]                 miss_cnt_o
);

  localparam int POP_W = $clog2(ICACHE_N_WAY + 1);

  logic [ICACHE_N_WAY-1:0] hit_vec;
  logic [WAY_IDX_W-1:0]    sel_way;
  logic [POP_W-1:0]        hit_count;
  logic                    multihit;
  logic                    hit_d;
  logic [FETCH_WIDTH-1:0]  chunks [ICACHE_N_WAY*N_CHUNK];
  logic [FETCH_WIDTH-1:0]  chunk;
  logic                    valid_q;
  logic                    load;
  logic                    rsp_fire;

  // Walk ways from high to low so the lowest matching index ends up in sel_way.
  always_comb begin
    hit_vec   = '0;
    sel_way   = '0;
    hit_count = '0;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
      hit_vec[w] = (read_tags_i[w*TAG_WIDTH +: TAG_WIDTH] == req_tag_i) & way_valid_i[w];
      if (hit_vec[w]) sel_way = WAY_IDX_W'(w);
      hit_count = hit_count + {{(POP_W-1){1'b0}}, hit_vec[w]};
    end
  end

  // Lines are stored way-major, so {way, chunk} directly indexes the flattened chunk array.
  always_comb begin
    for (int i = 0; i < ICACHE_N_WAY * N_CHUNK; i++) begin
      chunks[i] = data_rd_i[i*FETCH_WIDTH +: FETCH_WIDTH];
    end
  end

  assign chunk    = chunks[{sel_way, req_chunk_i}];
  assign multihit = hit_count > POP_W'(1);
  assign hit_d    = (|hit_vec) & ~multihit;

  assign req_ready_o = ~flush_i & (~valid_q | rsp_ready_i);
  assign rsp_valid_o = valid_q & ~flush_i;
  assign load        = req_valid_i & req_ready_o;
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q        <= 1'b0;
      rsp_hit_o      <= 1'b0;
      rsp_way_o      <= '0;
      rsp_multihit_o <= 1'b0;
      rsp_data_o     <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q        <= 1'b1;
      rsp_hit_o      <= hit_d;
      rsp_way_o      <= hit_d ? sel_way : '0;
      rsp_multihit_o <= multihit;
      rsp_data_o     <= hit_d ? chunk : '0;
    end else if (rsp_fire) begin
      valid_q <= 1'b0;
    end
  end

  // rsp_fire already excludes flushed responses, so killed results are never counted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (cnt_clear_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (rsp_fire) begin
      if (rsp_hit_o) begin
        if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
      end else begin
        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_sargantana_icache_checker_pipe.sv
// tb/tb_sargantana_icache_checker_pipe.sv - self-checking bench for sargantana_icache_checker_pipe
module tb_sargantana_icache_checker_pipe;

  localparam logic [79:0] DEF_TAGS = {20'h10003, 20'h10002, 20'h10001, 20'h10000};

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [19:0]   req_tag = '0;
  logic [1:0]    req_chunk = '0;
  logic [3:0]    way_valid = 4'hf;
  logic [79:0]   read_tags = DEF_TAGS;
  logic [2047:0] data_rd;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_hit;
  logic [1:0]    rsp_way;
  logic          rsp_multihit;
  logic [127:0]  rsp_data;
  logic          cnt_clear = 1'b0;
  logic [3:0]    hit_cnt;
  logic [3:0]    miss_cnt;

  int total = 0;
  int passed = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  sargantana_icache_checker_pipe #(
    .ICACHE_N_WAY(4), .TAG_WIDTH(20), .LINE_WIDTH(512), .FETCH_WIDTH(128), .CNT_WIDTH(4)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_tag_i(req_tag), .req_chunk_i(req_chunk),
    .way_valid_i(way_valid), .read_tags_i(read_tags), .data_rd_i(data_rd),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_hit_o(rsp_hit), .rsp_way_o(rsp_way), .rsp_multihit_o(rsp_multihit),
    .rsp_data_o(rsp_data), .cnt_clear_i(cnt_clear),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wv;
    logic [79:0] tags;
    logic [19:0] tag;
    logic [1:0]  chunk;
    logic        hit;
    logic [1:0]  way;
    logic        multi;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [127:0] pat(input int w, input int c);
    logic [7:0] b;
    b = 8'(w * 16 + c + 1);
    return {16{b}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [19:0] tag, input logic [1:0] c);
    req_tag   = tag;
    req_chunk = c;
    req_valid = 1'b1;
  endtask

  task automatic chk_rsp(input string name, input logic hit, input logic [1:0] way,
                         input logic multi, input logic [1:0] c);
    chk({name, "_valid"}, 128'(rsp_valid), 128'(1'b1));
    chk({name, "_hit"}, 128'(rsp_hit), 128'(hit));
    chk({name, "_way"}, 128'(rsp_way), 128'(way));
    chk({name, "_multihit"}, 128'(rsp_multihit), 128'(multi));
    chk({name, "_data"}, rsp_data, hit ? pat(int'(way), int'(c)) : 128'(0));
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "_hit_cnt"}, 128'(hit_cnt), 128'(exp_hits));
    chk({name, "_miss_cnt"}, 128'(miss_cnt), 128'(exp_miss));
  endtask

  initial begin
    for (int w = 0; w < 4; w++)
      for (int c = 0; c < 4; c++)
        data_rd[w*512 + c*128 +: 128] = pat(w, c);

    vecs[0] = '{4'hf, {20'h0aaaa, 20'h12345, 20'h0bbbb, 20'h0cccc}, 20'h12345, 2'd3, 1'b1, 2'd2, 1'b0};
    vecs[1] = '{4'h0, {20'h10003, 20'h10002, 20'h2468a, 20'h10000}, 20'h2468a, 2'd1, 1'b0, 2'd0, 1'b0};
    vecs[2] = '{4'hf, {20'h55555, 20'h10002, 20'h10001, 20'h55555}, 20'h55555, 2'd2, 1'b0, 2'd0, 1'b1};
    vecs[3] = '{4'h8, {20'h00777, 20'h10002, 20'h00777, 20'h10000}, 20'h00777, 2'd0, 1'b1, 2'd3, 1'b0};
    vecs[4] = '{4'hf, DEF_TAGS, 20'h10000, 2'd1, 1'b1, 2'd0, 1'b0};
    vecs[5] = '{4'hf, DEF_TAGS, 20'h3ffff, 2'd2, 1'b0, 2'd0, 1'b0};

    // Reset state
    #12;
    chk("rst_valid", 128'(rsp_valid), 128'(0));
    chk("rst_hit", 128'(rsp_hit), 128'(0));
    chk("rst_way", 128'(rsp_way), 128'(0));
    chk("rst_multihit", 128'(rsp_multihit), 128'(0));
    chk("rst_data", rsp_data, 128'(0));
    chk_cnt("rst");
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rst_ready", 128'(req_ready), 128'(1));

    // Table-driven single requests with the consumer always ready
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      way_valid = vecs[i].wv;
      read_tags = vecs[i].tags;
      rsp_ready = 1'b1;
      drive(vecs[i].tag, vecs[i].chunk);
      @(negedge clk);
      req_valid = 1'b0;
      chk_rsp($sformatf("vec%0d", i), vecs[i].hit, vecs[i].way, vecs[i].multi, vecs[i].chunk);
      if (vecs[i].hit) exp_hits++; else exp_miss++;
      @(negedge clk);
      chk($sformatf("vec%0d_drained", i), 128'(rsp_valid), 128'(0));
      chk_cnt($sformatf("vec%0d", i));
    end

    // Backpressure for 3 cycles, then back-to-back B, C, D
    way_valid = 4'hf;
    read_tags = DEF_TAGS;
    rsp_ready = 1'b0;
    drive(20'h10002, 2'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(20'h10001, 2'd2);
      #1;
      chk_rsp($sformatf("bp%0d", k), 1'b1, 2'd2, 1'b0, 2'd0);
      chk($sformatf("bp%0d_ready", k), 128'(req_ready), 128'(0));
      chk($sformatf("bp%0d_cnt", k), 128'(hit_cnt), 128'(exp_hits));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 128'(req_ready), 128'(1));
    exp_hits++;
    @(negedge clk);
    chk_rsp("b2b_b", 1'b1, 2'd1, 1'b0, 2'd2);
    drive(20'h10000, 2'd3);
    exp_hits++;
    @(negedge clk);
    chk_rsp("b2b_c", 1'b1, 2'd0, 1'b0, 2'd3);
    drive(20'h3ffff, 2'd1);
    exp_hits++;
    @(negedge clk);
    chk_rsp("b2b_d", 1'b0, 2'd0, 1'b0, 2'd1);
    req_valid = 1'b0;
    exp_miss++;
    @(negedge clk);
    chk("b2b_drained", 128'(rsp_valid), 128'(0));
    chk_cnt("b2b");

    // Flush kills a valid response with the consumer ready
    drive(20'h10003, 2'd1);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_valid", 128'(rsp_valid), 128'(0));
    chk("flush_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_after_valid", 128'(rsp_valid), 128'(0));
    chk("flush_after_ready", 128'(req_ready), 128'(1));
    chk_cnt("flush");

    // Clear coincident with a hit handshake
    drive(20'h10001, 2'd0);
    @(negedge clk);
    req_valid = 1'b0;
    cnt_clear = 1'b1;
    chk_rsp("clr_rsp", 1'b1, 2'd1, 1'b0, 2'd0);
    exp_hits = 0;
    exp_miss = 0;
    @(negedge clk);
    cnt_clear = 1'b0;
    chk_cnt("clr");

    // 17 back-to-back hits saturate the 4-bit hit counter at 15
    drive(20'h10002, 2'd3);
    for (int k = 0; k < 17; k++) @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    exp_hits = 15;
    chk_cnt("sat");

    // Async reset while a response is pending
    drive(20'h10000, 2'd2);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk_rsp("pre_arst", 1'b1, 2'd0, 1'b0, 2'd2);
    #2 rstn = 1'b0;
    #1;
    exp_hits = 0;
    chk("arst_valid", 128'(rsp_valid), 128'(0));
    chk("arst_hit", 128'(rsp_hit), 128'(0));
    chk("arst_way", 128'(rsp_way), 128'(0));
    chk("arst_data", rsp_data, 128'(0));
    chk_cnt("arst");
    @(negedge clk);
    rstn = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
